gmii_tx_arb: RTL

Frame-level arbiter sharing the single GMII transmit path of the RGMII adapter between N frame sources (e.g. IPv4 stack, ARP, raw/debug). Grants one requester at a time using round-robin priority, forwards its byte stream to the adapter's GMII TX inputs with one register stage, and enforces the inter-frame gap. It also enforces a maximum frame length and a grant timeout, and holds off while the TX PHY clock path reports reset. Sits directly upstream of the adapter in the `gmii_clk_125m` domain.

---
 rtl/eth_vlg_pkg.sv | 15 +
 rtl/rr_prio_enc.sv | 29 ++
 rtl/gmii_tx_arb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/eth_vlg_pkg.sv
// Shared Ethernet/GMII definitions: arbiter state encoding and default
// frame-timing constants.
package eth_vlg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XMIT  = 2'd2,
    IFG   = 2'd3
  } gmii_arb_state_t;

  localparam int unsigned GMII_IFG_DEFAULT     = 12;
  localparam int unsigned GMII_MAX_LEN_DEFAULT = 1530;

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_prio_enc #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned W = $clog2(N);

  int unsigned pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(ptr) + i) % N;
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = W'(pos);
      end
    end
  end

endmodule

// File: rtl/gmii_tx_arb.sv
// Frame-level round-robin arbiter for the shared GMII TX path: one register
// stage on the byte stream, inter-frame gap, length cap and grant timeout.
module gmii_tx_arb
  import eth_vlg_pkg::*;
#(
  parameter int unsigned N           = 2,
  parameter int unsigned IFG_BYTES   = GMII_IFG_DEFAULT,
  parameter int unsigned MAX_LEN     = GMII_MAX_LEN_DEFAULT,
  parameter int unsigned GNT_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_phy_rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  input  logic [N*8-1:0]       src_dat,
  input  logic [N-1:0]         src_val,
  input  logic [N-1:0]         src_err,
  output logic [7:0]           gmii_tx_dat,
  output logic                 gmii_tx_val,
  output logic                 gmii_tx_err,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 trunc
);

  localparam int unsigned W  = $clog2(N);
  localparam int unsigned TW = $clog2(GNT_TIMEOUT) + 1;
  localparam int unsigned IW = $clog2(IFG_BYTES) + 1;

  gmii_arb_state_t state;
  logic [W-1:0]    ptr;
  logic [W-1:0]    nxt_ptr;
  logic [W-1:0]    pick_idx;
  logic            pick_any;
  logic [15:0]     byte_cnt;
  logic [15:0]     nxt_cnt;
  logic            len_hit;
  logic [TW-1:0]   to_cnt;
  logic [IW-1:0]   ifg_cnt;
  logic [7:0]      sel_dat;
  logic            sel_val;
  logic            sel_err;

  rr_prio_enc #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_dat = '0;
    sel_val = 1'b0;
    sel_err = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner == W'(i)) begin
        sel_dat = src_dat[i*8 +: 8];
        sel_val = src_val[i];
        sel_err = src_err[i];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state == GRANT || state == XMIT) gnt[owner] = 1'b1;
  end

  always_comb begin
    if (state == GRANT)                    nxt_cnt = 16'd1;
    else if (byte_cnt >= 16'(MAX_LEN))     nxt_cnt = byte_cnt;
    else                                   nxt_cnt = byte_cnt + 16'd1;
  end

  assign len_hit = (nxt_cnt == 16'(MAX_LEN));
  assign nxt_ptr = (owner == W'(N - 1)) ? '0 : owner + W'(1);
  assign busy    = (state != IDLE);

  // The IFG counter starts at 1 after a normal end (the val-low cycle that
  // ended the frame already counts as idle on the output) and at 0 after a
  // truncation, where the cut byte is still leaving the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      ifg_cnt     <= '0;
      gmii_tx_dat <= '0;
      gmii_tx_val <= 1'b0;
      gmii_tx_err <= 1'b0;
      trunc       <= 1'b0;
    end else if (tx_phy_rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      ifg_cnt     <= '0;
      gmii_tx_dat <= '0;
      gmii_tx_val <= 1'b0;
      gmii_tx_err <= 1'b0;
      trunc       <= 1'b0;
    end else begin
      gmii_tx_dat <= '0;
      gmii_tx_val <= 1'b0;
      gmii_tx_err <= 1'b0;
      trunc       <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner  <= pick_idx;
            to_cnt <= '0;
            state  <= GRANT;
          end
        end
        GRANT, XMIT: begin
          if (sel_val) begin
            gmii_tx_dat <= sel_dat;
            gmii_tx_val <= 1'b1;
            gmii_tx_err <= sel_err | len_hit;
            trunc       <= len_hit;
            byte_cnt    <= nxt_cnt;
            if (len_hit) begin
              ifg_cnt <= '0;
              state   <= IFG;
            end else begin
              state   <= XMIT;
            end
          end else if (state == XMIT) begin
            ifg_cnt <= IW'(1);
            state   <= IFG;
          end else if (to_cnt == TW'(GNT_TIMEOUT - 1)) begin
            ptr   <= nxt_ptr;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        IFG: begin
          if (ifg_cnt >= IW'(IFG_BYTES)) begin
            ptr      <= nxt_ptr;
            byte_cnt <= '0;
            state    <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
